fetch_stage: RTL
================

# fetch_stage

- Instruction fetch stage: owns the PC and issues word fetches to instruction memory over a valid/ready request port.
- Buffers returned instructions and presents them, with their PC and PC+4, to decode.
- Decode slices `id_instr[6:0]` and `id_instr[14:12]` into the main decoder's `op`/`funct3`.
- Execute-stage branch/jump resolution redirects it; a redirect squashes all younger fetched work.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `imem_req_valid`, output, 1: fetch request valid.
- `imem_req_ready`, input, 1: memory accepts request this cycle.
- `imem_req_addr`, output, 32: word address of the request; bits [1:0] always 00.
- `imem_rsp_valid`, input, 1: response data valid. Arrives ≥1 cycle after request acceptance, in order.
- `imem_rsp_data`, input, 32: fetched instruction.
- `redirect_valid`, input, 1: branch taken / jal / jalr resolved in execute.
- `redirect_pc`, input, 32: new PC. Bits [1:0] ignored and forced to 00.
- `id_valid`, output, 1: `id_*` holds a valid instruction.
- `id_ready`, input, 1: decode consumes this cycle; low = decode stall.
- `id_instr`, output, 32: instruction. Reads 32'h0000_0013 (NOP) when `id_valid`=0.
- `id_pc`, output, 32: PC of `id_instr`.
- `id_pc_plus4`, output, 32: `id_pc`+4, modulo 2^32.

## Operation
- Fetch PC register `pc`. Increments by 4 on each request handshake (`imem_req_valid && imem_req_ready`). Wraps 32'hFFFF_FFFC → 0.
- At most one request outstanding. FSM states:
  - IDLE: none outstanding. On handshake → WAIT.
  - WAIT: one outstanding. On `imem_rsp_valid` the response is written to the buffer, then:
    - → WAIT if a new request handshakes the same cycle;
    - → IDLE otherwise.
  - DROP: one outstanding but squashed. On `imem_rsp_valid` the data is discarded → IDLE. No requests issued while in DROP.
- Output buffer: 2-entry FIFO of {instr, pc}.
  - Head drives `id_*`.
  - Pop when `id_valid && id_ready`.
  - Push on a non-squashed response.
- Request issue rule: `imem_req_valid` = !`redirect_valid` && state≠DROP && (occupancy after this cycle's pop + outstanding after this cycle's response) < 2.
  - May depend combinationally on `imem_rsp_valid` and `id_ready`; this is what allows back-to-back requests.
- Redirect has priority over every other event in its cycle:
  - `pc` ← `redirect_pc` & ~3.
  - Buffer emptied; any pop that cycle is ignored.
  - A same-cycle response is discarded.
  - No request issued.
  - Next state: WAIT→DROP, DROP stays DROP, IDLE stays IDLE. A same-cycle response on WAIT → IDLE.
- Redirect while in DROP retargets `pc` only.
- A response arriving in IDLE is a protocol error. It is ignored; the bench asserts on it.
- `reset` asserted at any time:
  - state=IDLE, buffer empty, `pc`=RESET_PC, `imem_req_valid`=0 during the reset cycle.
  - Memory shares the same reset, so no stale response can follow.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_req_addr`=RESET_PC.
  - `id_valid`=0, `id_instr`=32'h0000_0013, `id_pc`=0, `id_pc_plus4`=4.
- First request is in the first cycle after `reset` deasserts.
- Latency, with 1-cycle memory (`imem_req_ready`=1):
  - request accepted at cycle t;
  - response at t+1;
  - `id_valid` with that instruction at t+2.
- Steady state: 1 instruction/cycle while `id_ready`=1.
- Decode stall: at most one further response is accepted, filling the buffer to 2. Requests stop until a pop.
- Redirect in cycle r:
  - `id_valid`=0 at r+1;
  - request to the new PC at r+1 if not in DROP;
  - otherwise at the cycle after the squashed response.
- `id_*` are registered; no combinational path from `imem_rsp_*` to `id_*`.

## Structure
- Shared package `riscv_pkg`:
  - `NOP_INSTR` = 32'h0000_0013;
  - opcode constants shared with the main decoder;
  - fetch FSM state encoding (IDLE/WAIT/DROP).
- Sub-module `fetch_buffer`: parameterless 2-entry FIFO of 64-bit {instr, pc}.
  - Ports: `clk`, `reset`, `flush`, `push`, `push_data`, `pop`, `head`, `count[1:0]`.
  - Flush beats push/pop.
- FSM, PC logic and request logic stay in `fetch_stage`.

## Test plan
- Reset release, 1-cycle memory, `id_ready`=1:
  - requests to 0x0, 0x4, 0x8 on consecutive cycles;
  - `id_pc`=0x0 two cycles after the first request, then 0x4, 0x8 back-to-back.
- `id_ready` held low for 5 cycles after the first instruction:
  - exactly one extra response is buffered and no further requests issue;
  - on release, `id_pc` 0x0, 0x4 then new fetches; nothing is lost or duplicated.
- `redirect_valid` with `redirect_pc`=0x103 while a request is outstanding (3-cycle memory):
  - old response discarded;
  - next `imem_req_addr`=0x100;
  - `id_pc`=0x100 is the next valid output.
- Redirect in the same cycle as a response and a pop:
  - response dropped, buffer empty next cycle;
  - no request that cycle, request to the target next cycle.
- `RESET_PC`=32'hFFFF_FFF8: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; `id_pc_plus4` of FFFF_FFFC is 0.
- Assert `reset` mid-stream with a full buffer: next cycle `id_valid`=0, `id_instr`=0x13, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch stage and the main decoder.
//   NOP_INSTR      : canonical NOP (addi x0, x0, 0) shown to decode when idle
//   OPC_*          : major opcode values (id_instr[6:0])
//   F3_*           : branch funct3 values (id_instr[14:12])
//   fetch_state_e  : fetch request tracker state encoding
//   fetch_entry_t  : one buffered fetch result {instr, pc}
//   word_align     : clears the byte offset of an address
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,  // nothing outstanding
    FETCH_WAIT = 2'd1,  // one request outstanding, result wanted
    FETCH_DROP = 2'd2   // one request outstanding, result squashed
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched {instr, pc} pairs between memory and decode.
//   clk, reset : clock, synchronous active-high reset
//   flush      : empty the FIFO; wins over push and pop in the same cycle
//   push       : write push_data (ignored when full without a pop)
//   push_data  : 64-bit {instr, pc}
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry (undefined content when count == 0)
//   count      : number of valid entries, 0..2
module fetch_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic [63:0] push_data,
  input  logic        pop,
  output logic [63:0] head,
  output logic [1:0]  count
);

  logic [63:0] mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  cnt;
  logic        do_pop;
  logic        do_push;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one word request at a
// time to instruction memory, buffers results and presents them to decode.
//   RESET_PC        : PC of the first fetch after reset
//   clk, reset      : clock, synchronous active-high reset
//   imem_req_*      : request port (valid/ready, word address)
//   imem_rsp_*      : in-order response, at least one cycle after acceptance
//   redirect_*      : resolved branch/jump from execute; squashes younger work
//   id_valid/ready  : handshake toward decode
//   id_instr/pc/pc_plus4 : head instruction (NOP and pc 0 when id_valid = 0)
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [1:0]   buf_count;
  logic [63:0]  buf_head;
  fetch_entry_t head_entry;
  fetch_entry_t rsp_entry;
  logic         pop;
  logic         push;
  logic         slot_free;
  logic [1:0]   occ_next;
  logic         req_fire;

  assign id_valid = (buf_count != 2'd0);
  assign pop      = id_valid && id_ready;

  // Only a response to a live (non-squashed) request reaches the buffer.
  assign push = imem_rsp_valid && (state == FETCH_WAIT) && !redirect_valid;

  assign rsp_entry = '{instr: imem_rsp_data, pc: imem_req_tag()};

  // The outstanding request either stays in flight or lands in the buffer
  // this cycle; both occupy one slot, so WAIT counts as one either way.
  assign occ_next  = buf_count - {1'b0, pop} + {1'b0, state == FETCH_WAIT};
  assign slot_free = (state == FETCH_IDLE) ||
                     ((state == FETCH_WAIT) && imem_rsp_valid);

  assign imem_req_valid = !reset && !redirect_valid && slot_free &&
                          (occ_next < 2'd2);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // PC of the outstanding request is always pc - 4: pc advanced on its
  // handshake and cannot move again until the response has been seen,
  // except via redirect, which squashes that response anyway.
  function automatic logic [31:0] imem_req_tag();
    return pc - 32'd4;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH_IDLE;
      pc    <= word_align(RESET_PC);
    end else if (redirect_valid) begin
      pc <= word_align(redirect_pc);
      case (state)
        FETCH_WAIT: state <= imem_rsp_valid ? FETCH_IDLE : FETCH_DROP;
        FETCH_DROP: state <= imem_rsp_valid ? FETCH_IDLE : FETCH_DROP;
        default:    state <= FETCH_IDLE;
      endcase
    end else begin
      if (req_fire) pc <= pc + 32'd4;
      case (state)
        FETCH_IDLE: if (req_fire) state <= FETCH_WAIT;
        FETCH_WAIT: if (imem_rsp_valid) state <= req_fire ? FETCH_WAIT : FETCH_IDLE;
        FETCH_DROP: if (imem_rsp_valid) state <= FETCH_IDLE;
        default:    state <= FETCH_IDLE;
      endcase
    end
  end

  fetch_buffer u_buffer (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  assign head_entry  = fetch_entry_t'(buf_head);
  assign id_instr    = id_valid ? head_entry.instr : NOP_INSTR;
  assign id_pc       = id_valid ? head_entry.pc : 32'd0;
  assign id_pc_plus4 = id_pc + 32'd4;

endmodule
